// File: rtl/pwd_pkg.sv
// rtl/pwd_pkg.sv - shared state encoding and default code for the password lock
package pwd_pkg;

    localparam int DEF_CODE_W = 4;
    localparam logic [DEF_CODE_W-1:0] DEF_CODE = 4'b1001;

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_CHECK   = 2'd1;
    localparam logic [1:0] S_UNLOCK  = 2'd2;
    localparam logic [1:0] S_LOCKOUT = 2'd3;

    typedef enum logic [1:0] {
        ST_COLLECT = S_COLLECT,
        ST_CHECK   = S_CHECK,
        ST_UNLOCK  = S_UNLOCK,
        ST_LOCKOUT = S_LOCKOUT
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pwd_lock_ctrl_if.sv
// rtl/pwd_lock_ctrl_if.sv - entry/status bundle between the keypad side and the lock
interface pwd_lock_ctrl_if #(
    parameter int CODE_W = pwd_pkg::DEF_CODE_W
);
    logic              in;
    logic              in_valid;
    logic              abort;
    logic              set_code;
    logic [CODE_W-1:0] code_in;
    logic              out;
    logic              lockout;
    logic [1:0]        fail_cnt;

    modport master (
        output in, in_valid, abort, set_code, code_in,
        input  out, lockout, fail_cnt
    );

    modport slave (
        input  in, in_valid, abort, set_code, code_in,
        output out, lockout, fail_cnt
    );
endinterface

// File: rtl/pwd_timer.sv
// rtl/pwd_timer.sv - shared down-counter for the unlock and lockout windows
module pwd_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/pwd_lock_ctrl.sv
// rtl/pwd_lock_ctrl.sv - serial password lock with fail counting and timed lockout
module pwd_lock_ctrl
    import pwd_pkg::*;
#(
    parameter int                CODE_W         = DEF_CODE_W,
    parameter logic [CODE_W-1:0] DEFAULT_CODE   = CODE_W'(DEF_CODE),
    parameter int                MAX_FAILS      = 3,
    parameter int                UNLOCK_CYCLES  = 8,
    parameter int                LOCKOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    pwd_lock_ctrl_if.slave  bus
);
    localparam int TW = $clog2(max2(UNLOCK_CYCLES, LOCKOUT_CYCLES) + 1);
    localparam int BW = $clog2(CODE_W + 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(CODE_W - 1);
    localparam logic [1:0]    FAIL_LIMIT = 2'(MAX_FAILS);

    state_t            state;
    logic [CODE_W-1:0] entry;
    logic [CODE_W-1:0] code;
    logic [BW-1:0]     bit_cnt;
    logic [1:0]        fail_cnt;
    logic              out_r;
    logic              lockout_r;

    logic              match;
    logic              t_load;
    logic              t_dec;
    logic              t_zero;
    logic [TW-1:0]     t_val;

    assign match  = (entry == code);
    // Loaded while checking so the window count starts on the first open/locked cycle.
    assign t_load = (state == ST_CHECK);
    assign t_val  = match ? TW'(UNLOCK_CYCLES - 1) : TW'(LOCKOUT_CYCLES - 1);
    assign t_dec  = (state == ST_UNLOCK) || (state == ST_LOCKOUT);

    pwd_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_val),
        .dec      (t_dec),
        .zero     (t_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_COLLECT;
            entry     <= '0;
            bit_cnt   <= '0;
            fail_cnt  <= '0;
            code      <= DEFAULT_CODE;
            out_r     <= 1'b0;
            lockout_r <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (bus.abort) begin
                        entry   <= '0;
                        bit_cnt <= '0;
                    end else if (bus.in_valid) begin
                        entry <= {entry[CODE_W-2:0], bus.in};
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= ST_CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    entry <= '0;
                    if (match) begin
                        state    <= ST_UNLOCK;
                        out_r    <= 1'b1;
                        fail_cnt <= '0;
                    end else if ((fail_cnt + 2'd1) >= FAIL_LIMIT) begin
                        state     <= ST_LOCKOUT;
                        lockout_r <= 1'b1;
                        fail_cnt  <= FAIL_LIMIT;
                    end else begin
                        state    <= ST_COLLECT;
                        fail_cnt <= fail_cnt + 2'd1;
                    end
                end
                ST_UNLOCK: begin
                    if (bus.set_code) begin
                        code <= bus.code_in;
                    end
                    if (t_zero) begin
                        state <= ST_COLLECT;
                        out_r <= 1'b0;
                    end
                end
                ST_LOCKOUT: begin
                    if (t_zero) begin
                        state     <= ST_COLLECT;
                        lockout_r <= 1'b0;
                        fail_cnt  <= '0;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

    assign bus.out      = out_r;
    assign bus.lockout  = lockout_r;
    assign bus.fail_cnt = fail_cnt;
endmodule
